// File: rtl/cd_global_resp_distributor_pkg.sv
// cd_global_resp_distributor_pkg: header field layout and GLOBAL requester coordinate defaults
package cd_global_resp_distributor_pkg;
  localparam int NI = 4;
  localparam int NO = 8;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_HXO = 55;
  localparam int DEF_HXW = 4;
  localparam int DEF_HYO = 51;
  localparam int DEF_HYW = 4;
  localparam int DEF_RX [NO] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int DEF_RY [NO] = '{1, 1, 1, 1, 2, 2, 2, 2};
endpackage

// File: rtl/cd_rr_arb4.sv
// cd_rr_arb4: 4-way round-robin grant search starting at ptr; pointer state lives in the parent
module cd_rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       any
);
  logic [1:0] c;
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    c = '0;
    for (int j = 3; j >= 0; j--) begin
      c = ptr + 2'(j);
      if (en && req[c]) begin
        gnt_idx = c;
        any = 1'b1;
      end
    end
    gnt = any ? 4'b0001 << gnt_idx : 4'b0000;
  end
endmodule

// File: rtl/cd_global_resp_distributor.sv
// cd_global_resp_distributor: 4 LLC response streams routed by Hx/Hy to 8 requester output registers.
// Define CD_RESP_DROP_CNT_EN to add a saturating drop_cnt of unroutable flits.
module cd_global_resp_distributor
  import cd_global_resp_distributor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HXO = DEF_HXO,
  parameter int HXW = DEF_HXW,
  parameter int HYO = DEF_HYO,
  parameter int HYW = DEF_HYW,
  parameter int RX0 = DEF_RX[0], parameter int RX1 = DEF_RX[1],
  parameter int RX2 = DEF_RX[2], parameter int RX3 = DEF_RX[3],
  parameter int RX4 = DEF_RX[4], parameter int RX5 = DEF_RX[5],
  parameter int RX6 = DEF_RX[6], parameter int RX7 = DEF_RX[7],
  parameter int RY0 = DEF_RY[0], parameter int RY1 = DEF_RY[1],
  parameter int RY2 = DEF_RY[2], parameter int RY3 = DEF_RY[3],
  parameter int RY4 = DEF_RY[4], parameter int RY5 = DEF_RY[5],
  parameter int RY6 = DEF_RY[6], parameter int RY7 = DEF_RY[7]
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NI-1:0]        in_valid,
  output logic [NI-1:0]        in_ready,
  input  logic [NI*DATA_W-1:0] in_data,
  output logic [NO-1:0]        out_valid,
  input  logic [NO-1:0]        out_ready,
  output logic [NO*DATA_W-1:0] out_data,
  output logic                 err_unroutable
`ifdef CD_RESP_DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);
  localparam int RXA [NO] = '{RX0, RX1, RX2, RX3, RX4, RX5, RX6, RX7};
  localparam int RYA [NO] = '{RY0, RY1, RY2, RY3, RY4, RY5, RY6, RY7};
  logic [NI-1:0][DATA_W-1:0] din;
  logic [NO-1:0][DATA_W-1:0] dout_q;
  logic [NI-1:0][NO-1:0] match;
  logic [NO-1:0][NI-1:0] req, gnt;
  logic [NO-1:0][1:0] ptr_q, gidx;
  logic [NO-1:0] vld_q, free, any;
  logic [NI-1:0] granted, drop;
  logic err_q;
  assign din = in_data;
  assign out_data = dout_q;
  assign out_valid = vld_q;
  assign err_unroutable = err_q;
  assign free = ~vld_q | out_ready;
  always_comb begin
    match = '0;
    req = '0;
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NO; k++) begin
        match[i][k] = din[i][HXO-:HXW] == HXW'(RXA[k]) && din[i][HYO-:HYW] == HYW'(RYA[k]);
        req[k][i] = in_valid[i] & match[i][k];
      end
  end
  for (genvar k = 0; k < NO; k++) begin : g_arb
    cd_rr_arb4 u_arb (
      .req(req[k]), .ptr(ptr_q[k]), .en(free[k] & ~reset),
      .gnt(gnt[k]), .gnt_idx(gidx[k]), .any(any[k])
    );
  end
  // Each input matches at most one output, so OR-ing grant columns yields a single accept
  always_comb begin
    granted = '0;
    drop = '0;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < NO; k++) granted[i] = granted[i] | gnt[k][i];
      drop[i] = !reset && in_valid[i] && !(|match[i]);
    end
    in_ready = granted | drop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dout_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NO; k++) begin
        if (any[k]) begin
          dout_q[k] <= din[gidx[k]];
          vld_q[k] <= 1'b1;
          ptr_q[k] <= gidx[k] + 2'd1;
        end else if (out_ready[k]) vld_q[k] <= 1'b0;
      end
      err_q <= err_q | (|drop);
    end
  end
`ifdef CD_RESP_DROP_CNT_EN
  logic [7:0] cnt_q;
  logic [8:0] cnt_d;
  assign cnt_d = {1'b0, cnt_q} + 9'($countones(drop));
  assign drop_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d[8] ? 8'hFF : cnt_d[7:0];
  end
`endif
endmodule

// File: tb/tb_cd_global_resp_distributor.sv
// tb_cd_global_resp_distributor: directed-vector bench for the 4->8 response distributor
module tb_cd_global_resp_distributor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [255:0] in_data = '0;
  logic [7:0] out_valid;
  logic [7:0] out_ready = '1;
  logic [511:0] out_data;
  logic err_unroutable;
  int vecs = 0;
  int errs = 0;
`ifdef CD_RESP_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  always #5 clk = ~clk;
  cd_global_resp_distributor dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_unroutable(err_unroutable)
`ifdef CD_RESP_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  function automatic logic [63:0] flit(input logic [3:0] hx, input logic [3:0] hy, input logic [47:0] p);
    return {8'h00, hx, hy, p};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    out_ready = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    out_ready = '1;
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = flit(4'(i), 4'd1, 48'h11 + 48'(i));
    in_valid = 4'hF;
    tick();
    tick();
    vecs++; if (in_ready !== 4'h0) begin errs++; $display("FAIL reset_in_ready got %h exp 0", in_ready); end
    vecs++; if (out_valid !== 8'h00) begin errs++; $display("FAIL reset_out_valid got %h exp 00", out_valid); end
    vecs++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data got nonzero exp 0"); end
    vecs++; if (err_unroutable !== 1'b0) begin errs++; $display("FAIL reset_err got %b exp 0", err_unroutable); end
`ifdef CD_RESP_DROP_CNT_EN
    vecs++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
`endif
    in_valid = '0;
    reset = 1'b0;
  endtask
  task automatic test_single();
    do_reset();
    in_data[63:0] = flit(4'd2, 4'd1, 48'hA5A5_0001);
    in_valid = 4'b0001;
    #1;
    vecs++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL single_in_ready got %b exp 0001", in_ready); end
    tick();
    in_valid = '0;
    vecs++; if (out_valid !== 8'h04) begin errs++; $display("FAIL single_out_valid got %h exp 04", out_valid); end
    vecs++; if (out_data[2*64 +: 64] !== flit(4'd2, 4'd1, 48'hA5A5_0001)) begin errs++; $display("FAIL single_data got %h exp %h", out_data[2*64 +: 64], flit(4'd2, 4'd1, 48'hA5A5_0001)); end
    tick();
    vecs++; if (out_valid !== 8'h00) begin errs++; $display("FAIL single_drain got %h exp 00", out_valid); end
  endtask
  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = flit(4'd1, 4'd2, 48'h500 + 48'(i));
    in_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      vecs++; if (in_ready !== 4'(1 << order[c])) begin errs++; $display("FAIL contention_grant%0d got %b exp %b", c, in_ready, 4'(1 << order[c])); end
      tick();
      vecs++; if (out_valid !== 8'h20 || out_data[5*64 +: 64] !== flit(4'd1, 4'd2, 48'h500 + 48'(order[c])))
        begin errs++; $display("FAIL contention_out%0d got v=%h d=%h exp v=20 d=%h", c, out_valid, out_data[5*64 +: 64], flit(4'd1, 4'd2, 48'h500 + 48'(order[c]))); end
    end
    in_valid = '0;
  endtask
  task automatic test_ptr();
    do_reset();
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = flit(4'd1, 4'd2, 48'h700 + 48'(i));
    in_valid = 4'b0010;
    tick();
    in_valid = 4'hF;
    #1;
    vecs++; if (in_ready !== 4'b0100) begin errs++; $display("FAIL ptr_grant got %b exp 0100", in_ready); end
    tick();
    in_valid = '0;
    vecs++; if (out_data[5*64 +: 64] !== flit(4'd1, 4'd2, 48'h702)) begin errs++; $display("FAIL ptr_data got %h exp %h", out_data[5*64 +: 64], flit(4'd1, 4'd2, 48'h702)); end
  endtask
  task automatic test_backpressure();
    do_reset();
    out_ready = 8'h7F;
    in_data[63:0] = flit(4'd3, 4'd2, 48'hAAAA);
    in_valid = 4'b0001;
    #1;
    vecs++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL bp_accept_a got %b exp 0001", in_ready); end
    tick();
    in_data[63:0] = flit(4'd3, 4'd2, 48'hBBBB);
    for (int c = 0; c < 5; c++) begin
      #1;
      vecs++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL bp_block%0d got %b exp 0000", c, in_ready); end
      tick();
      vecs++; if (out_valid[7] !== 1'b1 || out_data[7*64 +: 64] !== flit(4'd3, 4'd2, 48'hAAAA))
        begin errs++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=%h", c, out_valid[7], out_data[7*64 +: 64], flit(4'd3, 4'd2, 48'hAAAA)); end
    end
    out_ready = 8'hFF;
    #1;
    vecs++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL bp_refill got %b exp 0001", in_ready); end
    tick();
    in_valid = '0;
    vecs++; if (out_valid[7] !== 1'b1 || out_data[7*64 +: 64] !== flit(4'd3, 4'd2, 48'hBBBB))
      begin errs++; $display("FAIL bp_b got v=%b d=%h exp v=1 d=%h", out_valid[7], out_data[7*64 +: 64], flit(4'd3, 4'd2, 48'hBBBB)); end
    tick();
    vecs++; if (out_valid !== 8'h00) begin errs++; $display("FAIL bp_drain got %h exp 00", out_valid); end
  endtask
  task automatic test_parallel();
    logic [3:0] hx [4] = '{4'd0, 4'd3, 4'd0, 4'd3};
    logic [3:0] hy [4] = '{4'd1, 4'd1, 4'd2, 4'd2};
    int dst [4] = '{0, 3, 4, 7};
    do_reset();
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = flit(hx[i], hy[i], 48'hC00 + 48'(i));
    in_valid = 4'hF;
    #1;
    vecs++; if (in_ready !== 4'hF) begin errs++; $display("FAIL par_in_ready got %b exp 1111", in_ready); end
    tick();
    in_valid = '0;
    vecs++; if (out_valid !== 8'h99) begin errs++; $display("FAIL par_out_valid got %h exp 99", out_valid); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (out_data[dst[i]*64 +: 64] !== flit(hx[i], hy[i], 48'hC00 + 48'(i)))
        begin errs++; $display("FAIL par_data%0d got %h exp %h", dst[i], out_data[dst[i]*64 +: 64], flit(hx[i], hy[i], 48'hC00 + 48'(i))); end
    end
  endtask
  task automatic test_unroutable();
    do_reset();
    in_data[3*64 +: 64] = flit(4'hF, 4'hF, 48'hDEAD);
    in_valid = 4'b1000;
    #1;
    vecs++; if (in_ready !== 4'b1000) begin errs++; $display("FAIL unr_in_ready got %b exp 1000", in_ready); end
    vecs++; if (err_unroutable !== 1'b0) begin errs++; $display("FAIL unr_err_early got %b exp 0", err_unroutable); end
    tick();
    in_valid = '0;
    vecs++; if (out_valid !== 8'h00) begin errs++; $display("FAIL unr_out_valid got %h exp 00", out_valid); end
    vecs++; if (err_unroutable !== 1'b1) begin errs++; $display("FAIL unr_err got %b exp 1", err_unroutable); end
`ifdef CD_RESP_DROP_CNT_EN
    vecs++; if (drop_cnt !== 8'd1) begin errs++; $display("FAIL unr_cnt1 got %0d exp 1", drop_cnt); end
`endif
    tick();
    tick();
    vecs++; if (err_unroutable !== 1'b1) begin errs++; $display("FAIL unr_err_sticky got %b exp 1", err_unroutable); end
`ifdef CD_RESP_DROP_CNT_EN
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = flit(4'hE, 4'hE, 48'(i));
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    vecs++; if (drop_cnt !== 8'd5) begin errs++; $display("FAIL unr_cnt4 got %0d exp 5", drop_cnt); end
    in_valid = 4'b1000;
    for (int c = 0; c < 300; c++) tick();
    in_valid = '0;
    vecs++; if (drop_cnt !== 8'd255) begin errs++; $display("FAIL unr_cnt_sat got %0d exp 255", drop_cnt); end
`endif
  endtask
  task automatic test_reset_mid();
    do_reset();
    out_ready = 8'h00;
    in_data[63:0] = flit(4'd1, 4'd1, 48'hF00D);
    in_data[3*64 +: 64] = flit(4'hF, 4'hF, 48'h0);
    in_valid = 4'b1001;
    tick();
    in_valid = '0;
    vecs++; if (out_valid !== 8'h02) begin errs++; $display("FAIL mid_loaded got %h exp 02", out_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 8'hFF;
    vecs++; if (out_valid !== 8'h00 || out_data !== '0) begin errs++; $display("FAIL mid_cleared got v=%h exp 00", out_valid); end
    vecs++; if (err_unroutable !== 1'b0) begin errs++; $display("FAIL mid_err got %b exp 0", err_unroutable); end
`ifdef CD_RESP_DROP_CNT_EN
    vecs++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL mid_cnt got %0d exp 0", drop_cnt); end
`endif
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_ptr();
    test_backpressure();
    test_parallel();
    test_unroutable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
